i2s_stream_tx: RTL and testbench



---
 rtl/i2s_stream_tx.sv | 155 +++++++++++++++
 tb/tb_i2s_stream_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stream_tx.sv
// I2S / left-justified stereo serializer: valid/ready pair FIFO feeding a frame register
// shifted out MSB-first. Define I2S_UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of muting.
module i2s_stream_tx #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int SCLK_DIV    = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int I2S_MODE    = 1
) (
    input  logic                        inp_clock,
    input  logic                        inp_reset,
    input  logic [SAMPLE_BITS-1:0]      inp_left,
    input  logic [SAMPLE_BITS-1:0]      inp_right,
    input  logic                        inp_valid,
    output logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] out_level,
    output logic                        out_underrun,
    output logic                        out_mclk,
    output logic                        out_sclk,
    output logic                        out_wclk,
    output logic                        out_data
);
    localparam int FRAME  = 2 * SLOT_BITS;
    localparam int BCW    = $clog2(FRAME);
    localparam int DW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int LW     = PW + 1;
    localparam int PAIR_W = 2 * SAMPLE_BITS;

    localparam logic [BCW-1:0] FRAME_LAST = BCW'(FRAME - 1);
    localparam logic [BCW-1:0] SLOT_C     = BCW'(SLOT_BITS);
    localparam logic [BCW-1:0] SAMP_C     = BCW'(SAMPLE_BITS);
    localparam logic [DW-1:0]  DIV_LAST   = DW'(SCLK_DIV - 1);
    localparam logic [LW-1:0]  DEPTH_C    = LW'(FIFO_DEPTH);

`ifdef I2S_UNDERRUN_HOLD_EN
    localparam bit HOLD_ON_UNDERRUN = 1'b1;
`else
    localparam bit HOLD_ON_UNDERRUN = 1'b0;
`endif

    logic [DW-1:0]          div_q, div_d;
    logic                   sclk_q, sclk_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   wclk_q, wclk_d;
    logic                   data_q, data_d;
    logic                   underrun_q, underrun_d;
    logic                   ready_q, ready_d;
    logic [LW-1:0]          level_q, level_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [SAMPLE_BITS-1:0] frame_l_q, frame_l_d;
    logic [SAMPLE_BITS-1:0] frame_r_q, frame_r_d;
    logic [PAIR_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PAIR_W-1:0]      mem_d [FIFO_DEPTH];

    logic                   tick, bit_evt, load, push, pop, empty, slot_right;
    logic [BCW-1:0]         pos, bit_idx;
    logic [SAMPLE_BITS-1:0] smp, smp_sh;

    always_comb begin
        tick      = (div_q == DIV_LAST);
        bit_evt   = tick && sclk_q;
        div_d     = tick ? '0 : div_q + DW'(1);
        sclk_d    = tick ? ~sclk_q : sclk_q;
        bit_cnt_d = bit_cnt_q;
        if (bit_evt) begin
            bit_cnt_d = (bit_cnt_q == FRAME_LAST) ? '0 : bit_cnt_q + BCW'(1);
        end

        // Philips mode delays the data position one bit behind the word clock
        if (I2S_MODE != 0) begin
            pos = (bit_cnt_d == '0) ? FRAME_LAST : bit_cnt_d - BCW'(1);
        end else begin
            pos = bit_cnt_d;
        end
        load = bit_evt && (pos == '0);

        empty = (level_q == '0);
        push  = inp_valid && ready_q;
        pop   = load && !empty;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {inp_left, inp_right};
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != DEPTH_C);

        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
        if (pop) begin
            {frame_l_d, frame_r_d} = mem_q[rd_ptr_q];
        end else if (load && !HOLD_ON_UNDERRUN) begin
            frame_l_d = '0;
            frame_r_d = '0;
        end
        underrun_d = load && empty;

        // Data follows the next bit position and next frame so it moves with WCLK
        wclk_d     = (bit_cnt_d >= SLOT_C);
        slot_right = (pos >= SLOT_C);
        bit_idx    = slot_right ? pos - SLOT_C : pos;
        smp        = slot_right ? frame_r_d : frame_l_d;
        smp_sh     = smp << bit_idx;
        data_d     = (bit_idx < SAMP_C) ? smp_sh[SAMPLE_BITS-1] : 1'b0;
    end

    always_ff @(posedge inp_clock or negedge inp_reset) begin
        if (!inp_reset) begin
            div_q      <= '0;
            sclk_q     <= 1'b0;
            bit_cnt_q  <= '0;
            wclk_q     <= 1'b0;
            data_q     <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b1;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            mem_q      <= '{default: '0};
        end else begin
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            bit_cnt_q  <= bit_cnt_d;
            wclk_q     <= wclk_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            mem_q      <= mem_d;
        end
    end

    assign out_mclk     = inp_clock;
    assign out_sclk     = sclk_q;
    assign out_wclk     = wclk_q;
    assign out_data     = data_q;
    assign out_ready    = ready_q;
    assign out_level    = level_q;
    assign out_underrun = underrun_q;
endmodule

// File: tb/tb_i2s_stream_tx.sv
// Bench for i2s_stream_tx: two configurations (Philips and left-justified with padding) driven
// by shared random stimulus and checked every cycle against a cycle-count/queue model.
module tb_i2s_stream_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] lft = '0;
    logic [15:0] rgt = '0;

    logic       rdy_a, und_a, mclk_a, sclk_a, wclk_a, dat_a;
    logic [3:0] lvl_a;
    logic       rdy_b, und_b, mclk_b, sclk_b, wclk_b, dat_b;
    logic [2:0] lvl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_stream_tx #(.SAMPLE_BITS(16), .SLOT_BITS(16), .SCLK_DIV(2), .FIFO_DEPTH(8), .I2S_MODE(1)) dut_a (
        .inp_clock(clk), .inp_reset(rst_n), .inp_left(lft), .inp_right(rgt), .inp_valid(vld),
        .out_ready(rdy_a), .out_level(lvl_a), .out_underrun(und_a), .out_mclk(mclk_a),
        .out_sclk(sclk_a), .out_wclk(wclk_a), .out_data(dat_a));

    i2s_stream_tx #(.SAMPLE_BITS(16), .SLOT_BITS(24), .SCLK_DIV(3), .FIFO_DEPTH(4), .I2S_MODE(0)) dut_b (
        .inp_clock(clk), .inp_reset(rst_n), .inp_left(lft), .inp_right(rgt), .inp_valid(vld),
        .out_ready(rdy_b), .out_level(lvl_b), .out_underrun(und_b), .out_mclk(mclk_b),
        .out_sclk(sclk_b), .out_wclk(wclk_b), .out_data(dat_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model parameters per instance: divider, slot, mode, depth
    int pd[2]   = '{2, 3};
    int ps[2]   = '{16, 24};
    int pm[2]   = '{1, 0};
    int pdep[2] = '{8, 4};

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          mn[2];
    logic [15:0] fl[2];
    logic [15:0] fr[2];
    logic        mu[2];

    // Model state describes outputs after mn clock edges since reset release
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    mn[k] = 0; fl[k] = '0; fr[k] = '0; mu[k] = 1'b0;
                end
                qa.delete();
                qb.delete();
            end
            for (int k = 0; k < 2; k++) begin
                int t, f, bc, pos, b, sz;
                logic [15:0] smp, sh;
                logic e_data;
                string nm;
                nm  = (k == 0) ? "a" : "b";
                t   = mn[k] / pd[k];
                f   = t / 2;
                bc  = f % (2 * ps[k]);
                pos = (bc + 2 * ps[k] - pm[k]) % (2 * ps[k]);
                b   = pos % ps[k];
                smp = (pos < ps[k]) ? fl[k] : fr[k];
                e_data = 1'b0;
                if (b < 16) begin
                    sh = smp >> (15 - b);
                    e_data = sh[0];
                end
                sz = (k == 0) ? qa.size() : qb.size();
                chk({nm, "_sclk"}, (k == 0) ? sclk_a : sclk_b, 32'(t % 2));
                chk({nm, "_wclk"}, (k == 0) ? wclk_a : wclk_b, 32'(bc >= ps[k]));
                chk({nm, "_data"}, (k == 0) ? dat_a : dat_b, 32'(e_data));
                chk({nm, "_level"}, (k == 0) ? 32'(lvl_a) : 32'(lvl_b), 32'(sz));
                chk({nm, "_ready"}, (k == 0) ? rdy_a : rdy_b, 32'(sz < pdep[k]));
                chk({nm, "_underrun"}, (k == 0) ? und_a : und_b, 32'(mu[k]));
            end
            if (rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    int nn, f2, pos2, sz2;
                    logic ld, pok;
                    logic [31:0] pr;
                    sz2 = (k == 0) ? qa.size() : qb.size();
                    pok = vld && (sz2 < pdep[k]);
                    nn  = mn[k] + 1;
                    ld  = 1'b0;
                    if ((nn % pd[k] == 0) && ((nn / pd[k]) % 2 == 0)) begin
                        f2   = nn / pd[k] / 2;
                        pos2 = (f2 % (2 * ps[k]) + 2 * ps[k] - pm[k]) % (2 * ps[k]);
                        ld   = (pos2 == 0);
                    end
                    mu[k] = 1'b0;
                    if (ld) begin
                        if (sz2 > 0) begin
                            if (k == 0) pr = qa.pop_front();
                            else        pr = qb.pop_front();
                            fl[k] = pr[31:16];
                            fr[k] = pr[15:0];
                        end else begin
                            mu[k] = 1'b1;
`ifndef I2S_UNDERRUN_HOLD_EN
                            fl[k] = '0;
                            fr[k] = '0;
`endif
                        end
                    end
                    if (pok) begin
                        if (k == 0) qa.push_back({lft, rgt});
                        else        qb.push_back({lft, rgt});
                    end
                    mn[k] = nn;
                end
            end
        end
    end

    // Serial bits captured on each SCLK rising edge, in order
    logic ra[256];
    logic rb[256];

    function automatic logic [15:0] word_a(input int s);
        logic [15:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) w = {w[14:0], ra[s + j]};
        return w;
    endfunction

    function automatic logic [15:0] word_b(input int s);
        logic [15:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) w = {w[14:0], rb[s + j]};
        return w;
    endfunction

    function automatic logic pad_b(input int s);
        logic o;
        o = 1'b0;
        for (int j = 0; j < 8; j++) o = o | rb[s + j];
        return o;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_sclk"}, sclk_a, 0);  chk({tag, "_b_sclk"}, sclk_b, 0);
        chk({tag, "_a_wclk"}, wclk_a, 0);  chk({tag, "_b_wclk"}, wclk_b, 0);
        chk({tag, "_a_data"}, dat_a, 0);   chk({tag, "_b_data"}, dat_b, 0);
        chk({tag, "_a_ready"}, rdy_a, 1);  chk({tag, "_b_ready"}, rdy_b, 1);
        chk({tag, "_a_level"}, lvl_a, 0);  chk({tag, "_b_level"}, lvl_b, 0);
        chk({tag, "_a_under"}, und_a, 0);  chk({tag, "_b_under"}, und_b, 0);
    endtask

    initial begin
        int ka, kb, ua, ub;
        logic pa, pb;
        logic [15:0] exp_l2, exp_r2;

        repeat (3) tick();
        chk_reset_vals("rst0");
        chk("mclk_a_high", mclk_a, 1);
        chk("mclk_b_high", mclk_b, 1);

        // One known pair, then let both instances run past their second frame
        rst_n = 1'b1; vld = 1'b1; lft = 16'hA5F0; rgt = 16'h0F0F;
        ka = 0; kb = 0; ua = 0; ub = 0; pa = 1'b0; pb = 1'b0;
        for (int n = 1; n <= 880; n++) begin
            tick();
            if (n == 1) begin
                vld = 1'b0;
                chk("a_level_one", lvl_a, 1);
                chk("b_level_one", lvl_b, 1);
            end
            if (sclk_a && !pa && ka < 256) begin ra[ka] = dat_a; ka++; end
            if (sclk_b && !pb && kb < 256) begin rb[kb] = dat_b; kb++; end
            pa = sclk_a; pb = sclk_b;
            ua += int'(und_a); ub += int'(und_b);
        end
`ifdef I2S_UNDERRUN_HOLD_EN
        exp_l2 = 16'hA5F0; exp_r2 = 16'h0F0F;
`else
        exp_l2 = 16'h0000; exp_r2 = 16'h0000;
`endif
        chk("a_left_word", word_a(1), 16'hA5F0);
        chk("a_right_word", word_a(17), 16'h0F0F);
        chk("a_left_frame2", word_a(33), exp_l2);
        chk("a_right_frame2", word_a(49), exp_r2);
        chk("b_left_word", word_b(48), 16'hA5F0);
        chk("b_left_pad", pad_b(64), 0);
        chk("b_right_word", word_b(72), 16'h0F0F);
        chk("b_right_pad", pad_b(88), 0);
        chk("b_left_frame2", word_b(96), exp_l2);
        chk("b_right_frame2", word_b(120), exp_r2);
        chk("a_underrun_count", ua, 6);
        chk("b_underrun_count", ub, 2);

        // Fill: 9 back-to-back pushes between frame loads
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; ua = 0;
        for (int n = 1; n <= 10; n++) begin tick(); ua += int'(und_a); end
        chk("a_first_load_underrun", ua, 1);
        for (int n = 11; n <= 19; n++) begin
            vld = 1'b1; lft = 16'($urandom); rgt = 16'($urandom);
            tick();
        end
        vld = 1'b0;
        chk("a_full_level", lvl_a, 8);
        chk("a_full_ready", rdy_a, 0);
        chk("b_full_level", lvl_b, 4);
        chk("b_full_ready", rdy_b, 0);
        for (int n = 20; n <= 132; n++) tick();
        chk("a_after_pop_level", lvl_a, 7);
        chk("a_after_pop_ready", rdy_a, 1);
        chk("b_still_full", lvl_b, 4);

        // Dense random traffic, then reset with data queued
        for (int i = 0; i < 1500; i++) begin
            vld = ($urandom_range(0, 7) == 0); lft = 16'($urandom); rgt = 16'($urandom);
            tick();
        end
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        tick(); tick();
        rst_n = 1'b1; ua = 0;
        for (int n = 1; n <= 10; n++) begin tick(); ua += int'(und_a); end
        chk("a_post_reset_underrun", ua, 1);
        chk("a_post_reset_level", lvl_a, 0);

        // Sparse random traffic so underruns occur
        for (int i = 0; i < 1500; i++) begin
            vld = ($urandom_range(0, 299) == 0); lft = 16'($urandom); rgt = 16'($urandom);
            tick();
        end
        vld = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
